// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Sequences one shared 1-bit add slice (two half adders plus an OR for the
// carry) over a WIDTH-bit operand pair, LSB first, one bit per clock.
// Host handshake: start (sampled in IDLE) -> busy during RUN -> one-cycle
// done pulse with sum/cout valid. sum/cout hold until the next completion.
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;

    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   res_sh_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;

    logic [1:0]         slice_s;     // {carry_out, sum_bit} of the shared slice
    logic [WIDTH-1:0]   res_next_s;
    logic               last_bit_s;
    logic               accept_s;
    logic               shift_s;
    logic               finish_s;

    // One-bit full add built from two half adders and an OR; returns {c, s}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic hs1;
        logic hc1;
        logic hs2;
        logic hc2;
        hs1 = x ^ y;
        hc1 = x & y;
        hs2 = hs1 ^ ci;
        hc2 = hs1 & ci;
        return {hc1 | hc2, hs2};
    endfunction

    // Shared add slice on the current LSBs and the result shift-in value.
    always_comb begin
        slice_s    = full_add(a_sh_r[0], b_sh_r[0], carry_r);
        res_next_s = {slice_s[0], res_sh_r[WIDTH-1:1]};
        last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));
    end

    // Next-state decode and datapath control strobes.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        shift_s  = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                shift_s = 1'b1;
                if (last_bit_s) begin
                    state_s  = ST_DONE;
                    finish_s = 1'b1;
                end else begin
                    state_s  = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand/result shift registers, carry flop and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            res_sh_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            res_sh_r <= {WIDTH{1'b0}};
            carry_r  <= cin;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (shift_s) begin
            a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
            res_sh_r <= res_next_s;
            carry_r  <= slice_s[1];
            cnt_r    <= cnt_r + CNT_W'(1);
        end else begin
            a_sh_r   <= a_sh_r;
            b_sh_r   <= b_sh_r;
            res_sh_r <= res_sh_r;
            carry_r  <= carry_r;
            cnt_r    <= cnt_r;
        end
    end

    // Registered handshake and result outputs; sum/cout load as DONE is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_RUN);
            done_r <= (state_s == ST_DONE);
            if (finish_s) begin
                sum_r  <= res_next_s;
                cout_r <= slice_s[1];
            end else begin
                sum_r  <= sum_r;
                cout_r <= cout_r;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl (WIDTH=8).
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks_total;
    int checks_passed;

    // Results of the last run_op call.
    int               r_busy_cnt;
    int               r_done_at;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start at a negedge, then watch negedge samples k=1,2,...
    // (k=1 is the cycle right after the accepting edge) until done, bounded.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
        @(negedge clk);
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
        r_busy_cnt = 0;
        r_done_at  = 0;
        r_sum      = 8'h00;
        r_cout     = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (busy === 1'b1) r_busy_cnt++;
            if (done === 1'b1) begin
                r_done_at = k;
                r_sum     = sum;
                r_cout    = cout;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        checks_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else checks_passed++;
        checks_total++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else checks_passed++;
        checks_total++;
        if (sum !== 8'h00) $display("FAIL reset_sum: got %h want 00", sum); else checks_passed++;
        checks_total++;
        if (cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", cout); else checks_passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_add(input string name, input logic [WIDTH-1:0] av,
                                  input logic [WIDTH-1:0] bv, input logic cv,
                                  input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        run_op(av, bv, cv);
        checks_total++;
        if (r_busy_cnt !== 8) $display("FAIL %s_busy_cycles: got %0d want 8", name, r_busy_cnt); else checks_passed++;
        checks_total++;
        if (r_done_at !== 9) $display("FAIL %s_done_cycle: got %0d want 9", name, r_done_at); else checks_passed++;
        checks_total++;
        if (r_sum !== exp_sum) $display("FAIL %s_sum: got %h want %h", name, r_sum, exp_sum); else checks_passed++;
        checks_total++;
        if (r_cout !== exp_cout) $display("FAIL %s_cout: got %b want %b", name, r_cout, exp_cout); else checks_passed++;
        // done must be a single-cycle pulse, result held afterwards
        @(negedge clk);
        checks_total++;
        if (done !== 1'b0 || sum !== exp_sum) $display("FAIL %s_hold: got done=%b sum=%h want done=0 sum=%h", name, done, sum, exp_sum); else checks_passed++;
    endtask

    task automatic test_truth_table();
        logic [WIDTH-1:0] tv_a   [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01};
        logic [WIDTH-1:0] tv_b   [8] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01};
        logic             tv_c   [8] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        logic [WIDTH-1:0] tv_exp [8] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h01, 8'h02, 8'h02, 8'h03};
        for (int i = 0; i < 8; i++) begin
            run_op(tv_a[i], tv_b[i], tv_c[i]);
            checks_total++;
            if (r_done_at !== 9) $display("FAIL tt%0d_done_cycle: got %0d want 9", i, r_done_at); else checks_passed++;
            checks_total++;
            if (r_sum !== tv_exp[i] || r_cout !== 1'b0)
                $display("FAIL tt%0d_sum: got %h/%b want %h/0", i, r_sum, r_cout, tv_exp[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_start_ignored();
        int done_at;
        done_at = 0;
        @(negedge clk);
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        a     = 8'hFF;   // operands change freely after accept
        b     = 8'hFF;
        cin   = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3 || k == 9) start = 1'b1;
            else start = 1'b0;
            if (k == 4) begin
                checks_total++;
                if (busy !== 1'b1) $display("FAIL ign_busy_mid: got %b want 1", busy); else checks_passed++;
            end
            if (done === 1'b1 && done_at == 0) begin
                done_at = k;
                checks_total++;
                if (sum !== 8'h46 || cout !== 1'b0) $display("FAIL ign_sum: got %h/%b want 46/0", sum, cout); else checks_passed++;
            end
            if (k == 10 || k == 11) begin
                checks_total++;
                if (busy !== 1'b0 || done !== 1'b0) $display("FAIL ign_after_done_k%0d: got busy=%b done=%b want 0/0", k, busy, done); else checks_passed++;
                checks_total++;
                if (sum !== 8'h46) $display("FAIL ign_sum_hold_k%0d: got %h want 46", k, sum); else checks_passed++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks_total++;
        if (done_at !== 9) $display("FAIL ign_done_cycle: got %0d want 9", done_at); else checks_passed++;
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);  // now at RUN cycle 4
        checks_total++;
        if (busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", busy); else checks_passed++;
        rst = 1'b1;
        #1;
        checks_total++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_ctrl: got busy=%b done=%b want 0/0", busy, done); else checks_passed++;
        checks_total++;
        if (sum !== 8'h00 || cout !== 1'b0) $display("FAIL rst_mid_result: got %h/%b want 00/0", sum, cout); else checks_passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (done === 1'b1 || busy === 1'b1) done_seen++;
            @(negedge clk);
        end
        checks_total++;
        if (done_seen !== 0) $display("FAIL rst_no_done: got %0d active cycles want 0", done_seen); else checks_passed++;
        run_op(8'h01, 8'h01, 1'b0);
        checks_total++;
        if (r_done_at !== 9 || r_sum !== 8'h02 || r_cout !== 1'b0)
            $display("FAIL rst_recover: got done_at=%0d sum=%h cout=%b want 9/02/0", r_done_at, r_sum, r_cout);
        else checks_passed++;
    endtask

    task automatic test_back_to_back();
        int d0;
        int d1;
        int ndone;
        d0 = 0;
        d1 = 0;
        ndone = 0;
        @(negedge clk);
        start = 1'b1;
        a     = 8'h03;
        b     = 8'h04;
        cin   = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                checks_total++;
                if (sum !== 8'h07) $display("FAIL b2b_sum%0d: got %h want 07", ndone, sum); else checks_passed++;
                if (ndone == 1) d0 = k;
                else begin
                    d1 = k;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        checks_total++;
        if (d1 - d0 !== 10 || ndone !== 2) $display("FAIL b2b_spacing: got %0d (n=%0d) want 10", d1 - d0, ndone); else checks_passed++;
        repeat (2) @(negedge clk);
        checks_total++;
        if (busy !== 1'b0) $display("FAIL b2b_idle: got busy=%b want 0", busy); else checks_passed++;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        test_reset();
        test_basic_add("add0f01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        test_basic_add("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        test_basic_add("addffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        test_basic_add("adda5", 8'hA5, 8'h3C, 1'b1, 8'hE2, 1'b0);
        test_truth_table();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
